crc16_frame_ctrl: RTL and testbench

CRC16_FRAME_CTRL -- requirements
Module: crc16_frame_ctrl

---
 rtl/crc16_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_crc16_frame_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc16_frame_ctrl
// Description : Byte-stream framer that runs a bit-serial CRC-16 over each
//               frame's payload and appends the CRC (high byte first).
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_frame_ctrl #(
    parameter logic [15:0] POLY = 16'h8005,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] crc_o,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_ACCEPT = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SEND   = 3'd2,
        ST_CRC_HI = 3'd3,
        ST_CRC_LO = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_crc;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_byte;
    logic        r_last;

    logic        w_bit;
    logic [15:0] w_shifted;
    logic [15:0] w_crc_next;

    // One CRC bit per SHIFT cycle, MSB of the latched byte first.
    assign w_bit      = r_byte[r_bit_cnt];
    assign w_shifted  = {r_crc[14:0], 1'b0};
    assign w_crc_next = (r_crc[15] ^ w_bit) ? (w_shifted ^ POLY) : w_shifted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_ACCEPT;
            r_crc     <= INIT;
            r_bit_cnt <= 3'd0;
            r_byte    <= 8'h00;
            r_last    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_ACCEPT: begin
                    if (s_valid) begin
                        r_byte    <= s_data;
                        r_last    <= s_last;
                        r_bit_cnt <= 3'd7;
                    end
                end
                ST_SHIFT: begin
                    r_crc <= w_crc_next;
                    if (r_bit_cnt != 3'd0) begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                ST_CRC_LO: begin
                    if (m_ready) begin
                        r_crc <= INIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        m_data       = 8'h00;
        m_last       = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == 3'd0) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                m_valid = 1'b1;
                m_data  = r_byte;
                if (m_ready) begin
                    w_next_state = r_last ? ST_CRC_HI : ST_ACCEPT;
                end
            end
            ST_CRC_HI: begin
                m_valid = 1'b1;
                m_data  = r_crc[15:8];
                if (m_ready) begin
                    w_next_state = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                m_valid = 1'b1;
                m_data  = r_crc[7:0];
                m_last  = 1'b1;
                if (m_ready) begin
                    w_next_state = ST_ACCEPT;
                end
            end
            default: begin
                w_next_state = ST_ACCEPT;
            end
        endcase
    end

    assign crc_o = r_crc;
    assign busy  = (r_state != ST_ACCEPT);

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc16_frame_ctrl
// Description : Directed self-checking bench for crc16_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc16_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [15:0] crc_o;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    logic [8:0]  egress_q[$];
    int          rise_q[$];
    logic        prev_mv = 1'b0;
    logic [7:0]  fr[16];

    crc16_frame_ctrl #(.POLY(16'h8005), .INIT(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .crc_o   (crc_o),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Record each egress transfer that the next rising edge will complete.
    always @(negedge clk) begin
        if (m_valid && !prev_mv) rise_q.push_back(cycle);
        prev_mv = m_valid;
        if (m_valid && m_ready && rst) egress_q.push_back({m_last, m_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int acc_cycle);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && waited < 100) begin
            tick();
            waited++;
        end
        check("s_ready_before_accept", {31'b0, s_ready}, 32'd1);
        tick();
        acc_cycle = cycle;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
    endtask

    task automatic wait_egress(input string tag, input int n);
        int waited;
        waited = 0;
        while (egress_q.size() < n && waited < 300) begin
            tick();
            waited++;
        end
        check($sformatf("%s_egress_count", tag), egress_q.size(), n);
    endtask

    // Sends fr[0..n-1] with m_ready high and checks payload, CRC and latency.
    task automatic run_frame(input string tag, input int n, input logic [15:0] exp_crc);
        int acc;
        int first_acc;
        first_acc = 0;
        egress_q.delete();
        rise_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_byte(fr[i], (i == n - 1), acc);
            if (i == 0) first_acc = acc;
        end
        wait_egress(tag, n + 2);
        if (egress_q.size() >= n + 2) begin
            for (int i = 0; i < n; i++)
                check($sformatf("%s_payload%0d", tag, i), egress_q[i], {1'b0, fr[i]});
            check($sformatf("%s_crc_hi", tag), egress_q[n], {1'b0, exp_crc[15:8]});
            check($sformatf("%s_crc_lo", tag), egress_q[n + 1], {1'b1, exp_crc[7:0]});
        end
        if (rise_q.size() > 0)
            check($sformatf("%s_latency", tag), rise_q[0] - first_acc, 32'd8);
        else
            check($sformatf("%s_latency_seen", tag), rise_q.size(), 32'd1);
        tick();
        check($sformatf("%s_crc_after", tag), crc_o, 32'h0000);
        check($sformatf("%s_busy_after", tag), busy, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;

        // Reset state
        repeat (3) tick();
        check("rst_m_valid", m_valid, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_last", m_last, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_crc", crc_o, 32'h0000);
        rst = 1'b1;
        tick();
        check("post_rst_s_ready", s_ready, 32'd1);
        repeat (3) tick();
        check("idle_m_valid", m_valid, 32'd0);

        fr[0] = 8'h00;
        run_frame("zero", 1, 16'h0000);
        fr[0] = 8'h01;
        run_frame("one", 1, 16'h8005);
        for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
        run_frame("ascii", 9, 16'hFEE8);

        // Downstream stall in SEND and CRC_HI
        egress_q.delete();
        m_ready = 1'b0;
        send_byte(8'h01, 1'b1, acc);
        check("stall_shift_s_ready", s_ready, 32'd0);
        check("stall_shift_busy", busy, 32'd1);
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_send_valid", m_valid, 32'd1);
            check("stall_send_data", m_data, 32'h01);
            check("stall_send_last", m_last, 32'd0);
            check("stall_send_s_ready", s_ready, 32'd0);
            check("stall_send_crc", crc_o, 32'h8005);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hi_valid", m_valid, 32'd1);
            check("stall_hi_data", m_data, 32'h80);
            check("stall_hi_last", m_last, 32'd0);
            tick();
        end
        m_ready = 1'b1;
        wait_egress("stall", 3);
        if (egress_q.size() >= 3) begin
            check("stall_b0", egress_q[0], {1'b0, 8'h01});
            check("stall_b1", egress_q[1], {1'b0, 8'h80});
            check("stall_b2", egress_q[2], {1'b1, 8'h05});
        end
        tick();

        // Reset while the third byte is shifting
        egress_q.delete();
        send_byte(8'h31, 1'b0, acc);
        send_byte(8'h32, 1'b0, acc);
        send_byte(8'h33, 1'b0, acc);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_crc", crc_o, 32'h0000);
        check("midrst_busy", busy, 32'd0);
        check("midrst_m_valid", m_valid, 32'd0);
        rst = 1'b1;
        repeat (20) tick();
        check("midrst_egress_count", egress_q.size(), 32'd2);
        check("midrst_idle_valid", m_valid, 32'd0);
        fr[0] = 8'h01;
        run_frame("after_rst", 1, 16'h8005);

        // Back-to-back frames
        fr[0] = 8'h01;
        run_frame("b2b_a", 1, 16'h8005);
        fr[0] = 8'h00;
        run_frame("b2b_b", 1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
